// File: rtl/eth_bridge_pkg.sv
// Shared types and defaults for the Ethernet TX bridge.
// FSM state encoding, frame-length type and default sizing parameters.
package eth_bridge_pkg;

    // Default minimum frame length in bytes and inter-frame gap in cycles
    localparam int unsigned MinLenDefault    = 60;
    localparam int unsigned IfgCyclesDefault = 12;

    // Byte counters and length descriptors are 11 bits (1..2047 bytes)
    typedef logic [10:0] len_t;

    // Frame controller state encoding
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t StIdle = 2'd0;
    localparam tx_state_t StSend = 2'd1;
    localparam tx_state_t StPad  = 2'd2;
    localparam tx_state_t StIfg  = 2'd3;

endpackage

// File: rtl/tx_frame_ctrl_if.sv
// Handshake bundle between the frame controller and its environment:
// length descriptor, byte FIFO, MAC byte stream and status.
// master = environment side, slave = frame controller side.
interface tx_frame_ctrl_if;
    import eth_bridge_pkg::*;

    logic        len_valid;
    len_t        len_data;
    logic        len_ready;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [7:0]  fifo_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frame_cnt;

    modport master (
        output len_valid, len_data, fifo_empty, fifo_data, tx_ready,
        input  len_ready, fifo_rd, tx_data, tx_valid, tx_last, busy, frame_cnt
    );

    modport slave (
        input  len_valid, len_data, fifo_empty, fifo_data, tx_ready,
        output len_ready, fifo_rd, tx_data, tx_valid, tx_last, busy, frame_cnt
    );

endinterface

// File: rtl/tx_skid_buf.sv
// Two-entry byte buffer between the FIFO read pipeline and the MAC output.
// Head byte reads as 0x00 while empty so the output bus idles at zero.
module tx_skid_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic [1:0] occ
);

    logic [7:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;

    // Storage, pointers and occupancy; caller never pushes when full or pops when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= 8'h00;
            mem_q[1] <= 8'h00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : 8'h00;
    assign occ       = cnt_q;

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame transmit controller: takes a length descriptor, streams that many
// bytes from a byte FIFO to the MAC through a 2-entry skid buffer, appends
// tx_last, then waits IFG_CYCLES idle cycles before the next descriptor.
// Build option: define TX_PAD_EN to zero-pad frames shorter than MIN_LEN.
module tx_frame_ctrl
    import eth_bridge_pkg::*;
#(
    parameter int unsigned MIN_LEN    = MinLenDefault,
    parameter int unsigned IFG_CYCLES = IfgCyclesDefault
) (
    input logic           clk,
    input logic           rst_n,
    tx_frame_ctrl_if.slave bus
);

`ifdef TX_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    localparam len_t        MinLen  = len_t'(MIN_LEN);
    localparam logic [15:0] IfgLast = 16'(IFG_CYCLES - 1);
    // With no gap configured a finished frame returns straight to idle
    localparam tx_state_t   StAfter = (IFG_CYCLES == 0) ? StIdle : StIfg;

    tx_state_t   state_q, state_d;
    len_t        rem_q, rem_d;
    len_t        len_q, len_d;
    logic [15:0] ifg_q, ifg_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        inflight_q;
    logic        len_ready_q;
`ifdef TX_PAD_EN
    len_t        pad_q, pad_d;
`endif

    logic [7:0] head_data;
    logic [1:0] occ;
    logic       pop;
    logic       in_send;
    logic       last_payload;
    logic       short_frame;
    logic       tx_hs;

    tx_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bus.fifo_data),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );

    assign in_send      = (state_q == StSend);
    // Head byte is the final payload byte once nothing else is buffered or pending
    assign last_payload = (occ == 2'd1) && !inflight_q && (rem_q == '0);
    assign short_frame  = PadEn && (len_q < MinLen);
    assign pop          = in_send && (occ != 2'd0) && bus.tx_ready;

    // Read only while the skid buffer can absorb everything already requested
    assign bus.fifo_rd = in_send && (rem_q != '0) && !bus.fifo_empty &&
                         (({1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);

    // Output byte stream: skid head while sending, zero bytes while padding
    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        case (state_q)
            StSend: begin
                bus.tx_valid = (occ != 2'd0);
                bus.tx_data  = head_data;
                bus.tx_last  = (occ != 2'd0) && last_payload && !short_frame;
            end
`ifdef TX_PAD_EN
            StPad: begin
                bus.tx_valid = 1'b1;
                bus.tx_last  = (pad_q == len_t'(1));
            end
`endif
            default: ;
        endcase
    end

    assign tx_hs = bus.tx_valid && bus.tx_ready;

    // Next-state, byte counters, gap timer and frame counter
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        len_d       = len_q;
        ifg_d       = ifg_q;
        frame_cnt_d = frame_cnt_q;
`ifdef TX_PAD_EN
        pad_d       = pad_q;
`endif
        if (bus.fifo_rd) begin
            rem_d = rem_q - len_t'(1);
        end
        case (state_q)
            StIdle: begin
                // Zero-length descriptors are accepted and dropped
                if (len_ready_q && bus.len_valid && (bus.len_data != '0)) begin
                    state_d = StSend;
                    rem_d   = bus.len_data;
                    len_d   = bus.len_data;
                end
            end
            StSend: begin
                if (pop && last_payload) begin
`ifdef TX_PAD_EN
                    if (short_frame) begin
                        state_d = StPad;
                        pad_d   = MinLen - len_q;
                    end else
`endif
                    begin
                        state_d = StAfter;
                        ifg_d   = '0;
                    end
                end
            end
`ifdef TX_PAD_EN
            StPad: begin
                if (bus.tx_ready) begin
                    if (pad_q == len_t'(1)) begin
                        state_d = StAfter;
                        ifg_d   = '0;
                    end else begin
                        pad_d = pad_q - len_t'(1);
                    end
                end
            end
`endif
            StIfg: begin
                if (ifg_q == IfgLast) begin
                    state_d = StIdle;
                end else begin
                    ifg_d = ifg_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (tx_hs && bus.tx_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // State registers; reset abandons any frame and drops in-flight reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            len_q       <= '0;
            ifg_q       <= '0;
            frame_cnt_q <= '0;
            inflight_q  <= 1'b0;
            len_ready_q <= 1'b0;
`ifdef TX_PAD_EN
            pad_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            len_q       <= len_d;
            ifg_q       <= ifg_d;
            frame_cnt_q <= frame_cnt_d;
            inflight_q  <= bus.fifo_rd;
            len_ready_q <= (state_d == StIdle);
`ifdef TX_PAD_EN
            pad_q       <= pad_d;
`endif
        end
    end

    assign bus.len_ready = len_ready_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Self-checking bench for tx_frame_ctrl: a queue model of the byte FIFO and
// of the expected MAC beat sequence, checked every cycle on the falling edge.
module tb_tx_frame_ctrl;
    import eth_bridge_pkg::*;

    localparam int MinLen = 60;
    localparam int Ifg    = 12;
`ifdef TX_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    tx_frame_ctrl_if bus ();

    tx_frame_ctrl #(
        .MIN_LEN    (MinLen),
        .IFG_CYCLES (Ifg)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  fifo_q [$];
    logic [7:0]  exp_d [$];
    bit          exp_l [$];
    logic [15:0] mcnt = 16'h0000;

    int          cyc         = 0;
    int          last_hs_cyc = 0;
    int          beats       = 0;
    int          frame_beats = 0;
    logic [7:0]  last_byte   = 8'h00;
    bit          gap_seen    = 1'b0;
    bit          chk_en      = 1'b0;
    bit          rdy_toggle  = 1'b0;
    int          stall_at    = 0;
    int          hold        = 0;
    int          rd_count    = 0;
    bit          rd_n        = 1'b0;
    bit          prev_stall  = 1'b0;
    logic [7:0]  prev_data   = 8'h00;
    logic        prev_last   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Byte FIFO model: data appears the cycle after a read; optional forced-empty window
    always @(posedge clk) begin
        #1;
        if (rd_n && fifo_q.size() != 0) begin
            bus.fifo_data = fifo_q.pop_front();
            rd_count++;
            if (stall_at != 0 && rd_count == stall_at) hold = 5;
        end
        bus.fifo_empty = (hold != 0) || (fifo_q.size() == 0);
        if (hold != 0) hold--;
    end

    // MAC ready: held high or toggling every cycle
    always @(posedge clk) begin
        #1;
        bus.tx_ready = rdy_toggle ? ~bus.tx_ready : 1'b1;
    end

    // Per-cycle comparison against the beat model
    always @(negedge clk) begin
        rd_n = rst_n && bus.fifo_rd;
        if (rst_n && chk_en) begin
            if (bus.fifo_rd) check("fifo_rd_while_empty", bus.fifo_empty, 0);
            check("frame_cnt", bus.frame_cnt, mcnt);
            if (prev_stall) begin
                check("stall_valid", bus.tx_valid, 1);
                check("stall_data", bus.tx_data, prev_data);
                check("stall_last", bus.tx_last, prev_last);
            end
            if (!bus.tx_valid && exp_d.size() != 0 && beats > 0) gap_seen = 1'b1;
            if (bus.tx_valid) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("tx_data", bus.tx_data, exp_d[0]);
                    check("tx_last", bus.tx_last, exp_l[0]);
                    if (bus.tx_ready) begin
                        beats++;
                        if (exp_l[0]) begin
                            mcnt++;
                            last_hs_cyc = cyc + 1;
                        end
                        if (bus.tx_last) begin
                            frame_beats = beats;
                            last_byte   = bus.tx_data;
                            beats       = 0;
                        end
                        exp_d.delete(0);
                        exp_l.delete(0);
                    end
                end
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            prev_last  = bus.tx_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Expected frame: payload base, base+1, ... then zero pad up to MinLen if enabled
    task automatic load_frame(input int len, input int base);
        bit pad;
        pad = PadEn && (len < MinLen);
        for (int i = 0; i < len; i++) begin
            fifo_q.push_back(8'(base + i));
            exp_d.push_back(8'(base + i));
            exp_l.push_back(!pad && (i == len - 1));
        end
        if (pad) begin
            for (int i = len; i < MinLen; i++) begin
                exp_d.push_back(8'h00);
                exp_l.push_back(i == MinLen - 1);
            end
        end
    endtask

    task automatic issue_len(input int len);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.len_valid = 1'b1;
        bus.len_data  = 11'(len);
        @(negedge clk);
        while (!bus.len_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.len_ready) check("len_handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.len_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (exp_d.size() != 0) check("frame_done_timeout", exp_d.size(), 0);
    endtask

    task automatic wait_idle(output int gap);
        int n;
        n = 0;
        while (!bus.len_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.len_ready) check("idle_timeout", 0, 1);
        gap = cyc - last_hs_cyc;
    endtask

    task automatic check_reset_outputs();
        check("rst_len_ready", bus.len_ready, 0);
        check("rst_fifo_rd", bus.fifo_rd, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_last", bus.tx_last, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_cnt", bus.frame_cnt, 16'h0000);
    endtask

    initial begin
        int lat;
        int gap;
        int n;
        bus.len_valid  = 1'b0;
        bus.len_data   = '0;
        bus.fifo_data  = 8'h00;
        bus.fifo_empty = 1'b1;
        bus.tx_ready   = 1'b1;

        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("len_ready_after_reset", bus.len_ready, 1);

        // 64-byte frame, full rate, latency and inter-frame gap
        load_frame(64, 0);
        issue_len(64);
        lat = 0;
        @(negedge clk);
        while (!bus.tx_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("first_latency", lat, 2);
        wait_done();
        check("len64_beats", frame_beats, 64);
        check("len64_last_byte", last_byte, 8'h3F);
        wait_idle(gap);
        check("ifg_gap", gap, 12);
        check("len64_frame_cnt", bus.frame_cnt, 16'd1);

        // Zero-length descriptor is swallowed
        issue_len(0);
        @(negedge clk);
        check("len0_busy", bus.busy, 0);
        check("len0_len_ready", bus.len_ready, 1);
        repeat (3) @(negedge clk);

        // Short frame, padded or exact depending on build
        load_frame(10, 8'h80);
        issue_len(10);
        wait_done();
        check("len10_beats", frame_beats, PadEn ? 60 : 10);
        check("len10_last_byte", last_byte, PadEn ? 8'h00 : 8'h89);
        wait_idle(gap);

        // Back-pressure toggling every cycle
        rdy_toggle = 1'b1;
        load_frame(32, 8'h40);
        issue_len(32);
        wait_done();
        check("len32_beats", frame_beats, PadEn ? 60 : 32);
        rdy_toggle = 1'b0;
        wait_idle(gap);

        // FIFO runs dry for 5 cycles after byte 15
        rd_count = 0;
        stall_at = 15;
        gap_seen = 1'b0;
        load_frame(40, 8'hA0);
        issue_len(40);
        wait_done();
        check("len40_valid_dropped", gap_seen, 1);
        check("len40_beats", frame_beats, PadEn ? 60 : 40);
        stall_at = 0;
        wait_idle(gap);

        // Reset in the middle of a 100-byte frame
        load_frame(100, 0);
        issue_len(100);
        n = 0;
        while (beats < 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("len100_reached_20", (beats >= 20) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        fifo_q.delete();
        exp_d.delete();
        exp_l.delete();
        mcnt     = 16'h0000;
        beats    = 0;
        hold     = 0;
        rd_count = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load_frame(5, 8'hC0);
        issue_len(5);
        wait_done();
        check("len5_beats", frame_beats, PadEn ? 60 : 5);
        check("len5_last_byte", last_byte, PadEn ? 8'h00 : 8'hC4);
        wait_idle(gap);
        check("len5_frame_cnt", bus.frame_cnt, 16'd1);

        // Frame counter wrap from 0xFFFF
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        mcnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        check("preset_frame_cnt", bus.frame_cnt, 16'hFFFF);
        load_frame(1, 8'h55);
        issue_len(1);
        wait_done();
        wait_idle(gap);
        check("wrap_frame_cnt", bus.frame_cnt, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_frame_ctrl.md
TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 The block SHALL have parameter MIN_LEN, default 60, minimum transmitted frame length in bytes.
REQ-002 The block SHALL have parameter IFG_CYCLES, default 12, idle cycles inserted after each frame.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 len_valid  input  1  frame length descriptor valid.
REQ-006 len_data  input  11  frame payload length in bytes.
REQ-007 len_ready  output  1  descriptor accepted when high with len_valid.
REQ-008 fifo_empty  input  1  byte FIFO empty flag.
REQ-009 fifo_rd  output  1  byte FIFO read strobe.
REQ-010 fifo_data  input  8  FIFO read data, valid one cycle after fifo_rd.
REQ-011 tx_data  output  8  byte to MAC.
REQ-012 tx_valid  output  1  tx_data valid.
REQ-013 tx_last  output  1  final byte of frame, qualified by tx_valid.
REQ-014 tx_ready  input  1  MAC accepts byte when high with tx_valid.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 frame_cnt  output  16  count of completed frames.

Function
REQ-017 The FSM SHALL have states IDLE, SEND, PAD, IFG.
REQ-018 len_ready SHALL be high only in IDLE; a handshake loads len_data into a remaining-byte counter and moves to SEND.
REQ-019 A descriptor with len_data = 0 SHALL be consumed with no output, FSM staying in IDLE.
REQ-020 In SEND, fifo_rd SHALL assert only when remaining > 0, fifo_empty = 0 and (skid occupancy + reads in flight - pop this cycle) < 2.
REQ-021 Each fifo_rd SHALL decrement the remaining counter by one; fifo_data SHALL be written into the skid buffer on the following cycle.
REQ-022 With tx_ready held high and FIFO non-empty, sustained throughput SHALL be one byte per cycle after a 2-cycle initial latency from the len handshake to first tx_valid.
REQ-023 While tx_valid = 1 and tx_ready = 0, tx_data and tx_last SHALL remain stable.
REQ-024 fifo_empty mid-frame SHALL stall reads; tx_valid SHALL drop when the skid buffer drains; no byte SHALL be lost, duplicated or reordered.
REQ-025 When the last payload byte handshakes and total sent < MIN_LEN with padding enabled, the FSM SHALL enter PAD and emit 0x00 bytes until total = MIN_LEN.
REQ-026 tx_last SHALL accompany exactly the final byte of the frame (payload or pad).
REQ-027 On the tx_last handshake the FSM SHALL enter IFG, hold tx_valid = 0 for IFG_CYCLES cycles, then return to IDLE.
REQ-028 frame_cnt SHALL increment on each tx_last handshake, wrapping 0xFFFF -> 0x0000.
REQ-029 Byte counters SHALL be 11 bits; lengths 1..2047 SHALL be transmitted unmodified.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, len_ready 0 during reset, fifo_rd 0, tx_valid 0, tx_last 0, tx_data 0x00, busy 0, frame_cnt 0, skid buffer empty, counters 0.
REQ-031 Reset mid-frame SHALL abandon the frame; no tx_last SHALL be emitted for it and in-flight reads SHALL be discarded.

Configuration
REQ-032 Macro TX_PAD_EN defined: short frames SHALL be padded per REQ-025.
REQ-033 Macro TX_PAD_EN undefined: PAD state SHALL not be compiled; frames SHALL be sent at len_data bytes exactly.

Structure
REQ-034 Package eth_bridge_pkg SHALL hold the FSM state typedef, MIN_LEN and IFG_CYCLES defaults and the 11-bit length type.
REQ-035 The 2-entry output buffer SHALL be a sub-module tx_skid_buf (push, pop, data, occupancy).

Verification
REQ-036 len=64, FIFO holds 0x00..0x3F, tx_ready=1 -> 64 beats in order, tx_last on 0x3F, frame_cnt=1, len_ready high after 12 idle cycles.
REQ-037 len=10, TX_PAD_EN defined -> 60 beats, beats 11..60 = 0x00, tx_last on beat 60; undefined -> 10 beats, tx_last on beat 10.
REQ-038 len=32, tx_ready toggling every cycle -> 32 unique ordered beats, data stable during stalls.
REQ-039 len=40, fifo_empty high for 5 cycles after byte 15 -> no fifo_rd while empty, tx_valid drops, bytes 16..40 follow intact.
REQ-040 rst_n low at byte 20 of len=100 -> outputs per REQ-030 immediately; next descriptor len=5 sends 5 bytes correctly.
REQ-041 frame_cnt preset to 0xFFFF via 65535 len=1 frames (or force) -> next frame gives 0x0000.
